rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Write-side master for the triple-ported register file. Drives the file's write port (dst_addr, dst, we).
- Merges two result producers:
  - single-cycle ALU results;
  - long-latency load/divide results, buffered in a small in-order FIFO.
- Exports a pending-destination mask so decode/hazard logic can stall readers of registers whose values are still in flight.
- Sits between execute/memory stages and the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- DEPTH, 4, long-latency FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  long-latency result offered
- ld_ready  out  1  FIFO can accept
- ld_rd  in  ADDR_W  long-latency destination
- ld_data  in  DATA_W  long-latency result
- dst_addr  out  ADDR_W  register-file write address (registered)
- dst  out  DATA_W  register-file write data (registered)
- we  out  1  register-file write enable (registered)
- pending  out  2^ADDR_W  bit r set = a write to r is in FIFO or output stage
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy incl. squashed entries

Behaviour:
- Reset (sync, rst=1 at posedge):
  - we=0, dst_addr=0, dst=0.
  - FIFO emptied: fifo_count=0; all squash bits cleared.
  - pending=0.
  - Reset mid-operation discards all buffered and staged writes; no write issues on the following cycle.
- Handshakes:
  - ld_ready = (fifo_count != DEPTH), from registered state only.
  - alu_ready = (fifo_count != DEPTH). When the FIFO is full, its head has priority and the ALU is stalled.
  - Neither ready depends combinationally on its valid.
- Arbitration, evaluated each cycle:
  - alu accepted (alu_valid & alu_ready): ALU result goes to the output stage; FIFO does not pop.
  - Otherwise, if the FIFO is non-empty, pop the head into the output stage.
  - Otherwise the output stage loads we=0.
- Latency: exactly 1 cycle from an accepted ALU handshake, or from a FIFO pop, to we/dst_addr/dst valid. A new write can issue every cycle.
- x0 rule: a result with rd==0 is accepted (handshake completes) but never produces we=1.
  - ALU rd==0: output loads we=0.
  - ld rd==0: not enqueued.
- FIFO:
  - In-order, DEPTH entries {rd, data, squash}.
  - Simultaneous push and pop are allowed: count unchanged. This is reachable only when the FIFO is not full, or after a pop of a full FIFO on the next cycle.
  - Pointers wrap modulo DEPTH.
- Pending mask:
  - Bit r = OR over valid, non-squashed FIFO entries with rd==r, OR (we & dst_addr==r) of the output stage.
  - Computed from registered state; bit 0 is always 0.
- WAW squash:
  - An accepted ALU write to rd that matches any buffered non-squashed entry sets that entry's squash bit in the same cycle. The ALU value is newer and must survive.
  - A squashed entry still pops in turn but drives we=0 for that cycle.
- Same-cycle ld push with rd equal to an accepted ALU rd: the new entry is enqueued non-squashed, because the load is newer.
- Data width: dst is passed through unmodified. No arithmetic is performed on data.

Test Plan:
- Reset then idle: hold rst 2 cycles with alu_valid=1 -> we=0, pending=0, fifo_count=0, alu_ready=1, ld_ready=1.
- ALU stream: alu rd=5 data=0xDEADBEEF at cycle t -> at t+1 we=1, dst_addr=5, dst=0xDEADBEEF. Back-to-back rd=6/7 -> consecutive writes, no bubbles.
- FIFO fill/drain: 4 ld pushes rd=1..4 while ALU busy every cycle -> fifo_count=4, ld_ready=0, alu_ready=0, pending=0x1E. Next 4 cycles -> writes rd 1,2,3,4 in order; then ready bits return to 1.
- x0 drop: alu rd=0 data=0x55, then ld rd=0 -> both handshakes complete, we stays 0, fifo_count stays 0.
- WAW squash: FIFO holds rd=9 data=0x11; alu rd=9 data=0x22 -> next cycle writes 0x22. The popped 0x11 entry later gives we=0, and pending[9] clears after the 0x22 write.
- Mid-operation reset: FIFO holding 3 entries, rst pulse 1 cycle -> next cycle we=0, fifo_count=0, pending=0. No stale write appears afterwards.

Source files
------------

// File: rtl/rf_writeback.sv
// rf_writeback: write-side master for the triple-ported register file.
//
// Merges two result producers onto the single register-file write port:
//   - ALU results, which complete in one cycle and go straight to the
//     output stage;
//   - long-latency (load/divide) results, buffered in a small in-order FIFO
//     and drained whenever the ALU is not using the output stage.
// It also exports a pending-destination mask so that decode/hazard logic can
// stall readers of registers whose values are still in flight.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   alu_valid/alu_ready  ALU result handshake; alu_rd, alu_data payload
//   ld_valid/ld_ready    long-latency result handshake; ld_rd, ld_data payload
//   dst_addr, dst, we    registered register-file write port
//   pending              bit r set = a write to r is buffered or staged
//   fifo_count           FIFO occupancy, squashed entries included
//
// Handshake semantics (both producer ports): a transfer happens on a rising
// clock edge where valid and ready are both 1. ready is a function of
// registered state only and never looks at valid, so a producer may hold
// valid and wait. Once offered, the payload must stay stable until accepted.

module rf_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ADDR_W-1:0]         ld_rd,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [ADDR_W-1:0]         dst_addr,
  output logic [DATA_W-1:0]         dst,
  output logic                      we,
  output logic [(1<<ADDR_W)-1:0]    pending,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage: one entry per buffered long-latency result.
  logic [ADDR_W-1:0] fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_sq;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              alu_acc;
  logic              ld_acc;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  entry_valid;
  logic [DEPTH-1:0]  squash_hit;
  logic [DEPTH-1:0]  sq_next;
  logic [PTR_W-1:0]  offset;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // When full, the FIFO head owns the output stage, so the ALU is stalled too.
  assign alu_ready = ~full;
  assign ld_ready  = ~full;

  assign alu_acc = alu_valid & alu_ready;
  assign ld_acc  = ld_valid & ld_ready;

  // Results for x0 complete the handshake but are never buffered.
  assign push = ld_acc & (ld_rd != '0);
  // An accepted ALU result takes the output stage; the FIFO waits.
  assign pop  = ~alu_acc & ~empty;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
    end
  end

  // WAW: an accepted ALU write makes every older buffered write to the same
  // register obsolete. Those entries still drain in order but write nothing.
  always_comb begin
    squash_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_hit[i] = alu_acc & (alu_rd != '0) & entry_valid[i] &
                      ~fifo_sq[i] & (fifo_rd[i] == alu_rd);
    end
  end

  // The slot being pushed is never live (push implies not full), so clearing
  // its squash bit here cannot undo a squash. A same-cycle load to the ALU's
  // register is newer than the ALU value and must stay live.
  always_comb begin
    sq_next = fifo_sq | squash_hit;
    if (push) begin
      sq_next[wr_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fifo_sq  <= '0;
      we       <= 1'b0;
      dst_addr <= '0;
      dst      <= '0;
    end else begin
      fifo_sq <= sq_next;

      if (push) begin
        fifo_rd[wr_ptr]   <= ld_rd;
        fifo_data[wr_ptr] <= ld_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Output stage: one-cycle latency from acceptance or pop to the write.
      if (alu_acc) begin
        we       <= (alu_rd != '0);
        dst_addr <= alu_rd;
        dst      <= alu_data;
      end else if (pop) begin
        we       <= ~fifo_sq[rd_ptr];
        dst_addr <= fifo_rd[rd_ptr];
        dst      <= fifo_data[rd_ptr];
      end else begin
        we <= 1'b0;
      end
    end
  end

  // Pending mask from registered state only: live, non-squashed FIFO entries
  // plus the write currently presented to the register file.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && !fifo_sq[i]) begin
        pending[fifo_rd[i]] = 1'b1;
      end
    end
    if (we) begin
      pending[dst_addr] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_rf_writeback.sv
// Testbench for rf_writeback: directed scenarios followed by a randomized run
// checked against a queue-based reference model of the write-back rules.

module tb_rf_writeback;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int NREG   = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int EW     = 1 + ADDR_W + DATA_W;

  // Clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst;
  logic              we;
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .dst_addr(dst_addr), .dst(dst), .we(we), .pending(pending), .fifo_count(fifo_count)
  );

  // Reference model: buffered writes as {squash, rd, data}, plus output stage.
  logic [EW-1:0]     exp_q[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  function automatic logic [NREG-1:0] exp_pending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (exp_q[i]) begin
      if (!exp_q[i][EW-1]) p[exp_q[i][DATA_W +: ADDR_W]] = 1'b1;
    end
    if (m_we) p[m_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_step(input logic r, input logic av, input logic [ADDR_W-1:0] ar,
                            input logic [DATA_W-1:0] ad, input logic lv,
                            input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ldd);
    logic          full;
    logic [EW-1:0] e;
    if (r) begin
      exp_q.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      full = (exp_q.size() == DEPTH);
      if (av && !full) begin
        m_we = (ar != 0); m_addr = ar; m_data = ad;
        if (ar != 0) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            if (e[DATA_W +: ADDR_W] == ar) begin
              e[EW-1] = 1'b1;
              exp_q[i] = e;
            end
          end
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_we = !e[EW-1]; m_addr = e[DATA_W +: ADDR_W]; m_data = e[DATA_W-1:0];
      end else begin
        m_we = 1'b0;
      end
      if (lv && !full && lr != 0) exp_q.push_back({1'b0, lr, ldd});
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hCAFE_0001;
    tick(); tick();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0b expected 0", we); end
    checks++; if (dst_addr !== '0) begin failures++; $display("FAIL reset_dst_addr: got %0h expected 0", dst_addr); end
    checks++; if (dst !== '0) begin failures++; $display("FAIL reset_dst: got %0h expected 0", dst); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending: got %0h expected 0", pending); end
    checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready: got %0b expected 1", alu_ready); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready: got %0b expected 1", ld_ready); end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL idle_we: got %0b expected 0", we); end
  endtask

  task automatic test_alu_stream();
    logic [DATA_W-1:0] d;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    checks++; if (we !== 1'b1 || dst_addr !== 5'd5 || dst !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL alu_first: got we=%0b addr=%0d data=%0h expected we=1 addr=5 data=deadbeef", we, dst_addr, dst); end
    for (int r = 6; r <= 7; r++) begin
      d = $urandom;
      alu_rd = ADDR_W'(r); alu_data = d;
      tick();
      checks++; if (we !== 1'b1 || dst_addr !== ADDR_W'(r) || dst !== d) begin
        failures++; $display("FAIL alu_b2b: got we=%0b addr=%0d data=%0h expected we=1 addr=%0d data=%0h", we, dst_addr, dst, r, d); end
    end
    idle_inputs();
    tick();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL alu_idle_we: got %0b expected 0", we); end
  endtask

  task automatic test_fifo_fill();
    logic [DATA_W-1:0] d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      alu_valid = 1'b1; alu_rd = '0; alu_data = $urandom;
      ld_valid = 1'b1; ld_rd = ADDR_W'(i + 1); ld_data = d[i];
      tick();
    end
    idle_inputs();
    checks++; if (fifo_count !== CNT_W'(4)) begin failures++; $display("FAIL fill_count: got %0d expected 4", fifo_count); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL fill_ld_ready: got %0b expected 0", ld_ready); end
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL fill_alu_ready: got %0b expected 0", alu_ready); end
    checks++; if (pending !== NREG'(32'h1E)) begin failures++; $display("FAIL fill_pending: got %0h expected 1e", pending); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (we !== 1'b1 || dst_addr !== ADDR_W'(i + 1) || dst !== d[i]) begin
        failures++; $display("FAIL drain_write: got we=%0b addr=%0d data=%0h expected we=1 addr=%0d data=%0h", we, dst_addr, dst, i + 1, d[i]); end
    end
    checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      failures++; $display("FAIL drain_ready: got alu=%0b ld=%0b expected 1 1", alu_ready, ld_ready); end
    tick();
    checks++; if (we !== 1'b0 || pending !== '0 || fifo_count !== '0) begin
      failures++; $display("FAIL drain_idle: got we=%0b pending=%0h count=%0d expected 0 0 0", we, pending, fifo_count); end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h55;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_alu_ready: got %0b expected 1", alu_ready); end
    tick();
    checks++; if (we !== 1'b0 || fifo_count !== '0) begin
      failures++; $display("FAIL x0_alu: got we=%0b count=%0d expected 0 0", we, fifo_count); end
    idle_inputs();
    ld_valid = 1'b1; ld_rd = '0; ld_data = 32'h66;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL x0_ld_ready: got %0b expected 1", ld_ready); end
    tick();
    idle_inputs();
    checks++; if (we !== 1'b0 || fifo_count !== '0) begin
      failures++; $display("FAIL x0_ld: got we=%0b count=%0d expected 0 0", we, fifo_count); end
    tick();
    checks++; if (we !== 1'b0 || fifo_count !== '0 || pending !== '0) begin
      failures++; $display("FAIL x0_after: got we=%0b count=%0d pending=%0h expected 0 0 0", we, fifo_count, pending); end
  endtask

  task automatic test_waw();
    alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h11;
    tick();
    idle_inputs();
    checks++; if (fifo_count !== CNT_W'(1) || pending !== NREG'(1 << 9)) begin
      failures++; $display("FAIL waw_buffered: got count=%0d pending=%0h expected 1 200", fifo_count, pending); end
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h22;
    tick();
    idle_inputs();
    checks++; if (we !== 1'b1 || dst_addr !== 5'd9 || dst !== 32'h22) begin
      failures++; $display("FAIL waw_alu_write: got we=%0b addr=%0d data=%0h expected we=1 addr=9 data=22", we, dst_addr, dst); end
    checks++; if (fifo_count !== CNT_W'(1) || pending !== NREG'(1 << 9)) begin
      failures++; $display("FAIL waw_squashed: got count=%0d pending=%0h expected 1 200", fifo_count, pending); end
    tick();
    checks++; if (we !== 1'b0 || fifo_count !== '0 || pending !== '0) begin
      failures++; $display("FAIL waw_pop_squashed: got we=%0b count=%0d pending=%0h expected 0 0 0", we, fifo_count, pending); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b1; ld_rd = ADDR_W'(10 + i); ld_data = $urandom;
      tick();
    end
    idle_inputs();
    checks++; if (fifo_count !== CNT_W'(3)) begin failures++; $display("FAIL midrst_fill: got %0d expected 3", fifo_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (we !== 1'b0 || fifo_count !== '0 || pending !== '0) begin
      failures++; $display("FAIL midrst_clear: got we=%0b count=%0d pending=%0h expected 0 0 0", we, fifo_count, pending); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (we !== 1'b0) begin failures++; $display("FAIL midrst_stale: got we=%0b expected 0 at cycle %0d", we, i); end
    end
  endtask

  task automatic test_random();
    logic              r;
    logic              av;
    logic              lv;
    logic [ADDR_W-1:0] ar;
    logic [ADDR_W-1:0] lr;
    logic [DATA_W-1:0] ad;
    logic [DATA_W-1:0] ldd;
    logic              exp_rdy;
    rst = 1'b1; idle_inputs();
    model_step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      av  = ($urandom_range(0, 99) < 45);
      lv  = ($urandom_range(0, 99) < 60);
      ar  = ADDR_W'($urandom_range(0, 7));
      lr  = ADDR_W'($urandom_range(0, 7));
      ad  = $urandom;
      ldd = $urandom;
      rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
      ld_valid = lv; ld_rd = lr; ld_data = ldd;
      exp_rdy = (exp_q.size() != DEPTH);
      checks++; if (alu_ready !== exp_rdy || ld_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_ready c=%0d: got alu=%0b ld=%0b expected %0b", c, alu_ready, ld_ready, exp_rdy); end
      model_step(r, av, ar, ad, lv, lr, ldd);
      tick();
      checks++; if (we !== m_we) begin
        failures++; $display("FAIL rand_we c=%0d: got %0b expected %0b", c, we, m_we); end
      if (m_we) begin
        checks++; if (dst_addr !== m_addr || dst !== m_data) begin
          failures++; $display("FAIL rand_write c=%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", c, dst_addr, dst, m_addr, m_data); end
      end
      checks++; if (pending !== exp_pending()) begin
        failures++; $display("FAIL rand_pending c=%0d: got %0h expected %0h", c, pending, exp_pending()); end
      checks++; if (fifo_count !== CNT_W'(exp_q.size())) begin
        failures++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, fifo_count, exp_q.size()); end
    end
    rst = 1'b0; idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_stream();
    test_fifo_fill();
    test_x0();
    test_waw();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
